wb_cmd_master: RTL
==================

Name: wb_cmd_master

Overview:
- Wishbone classic initiator. Turns a simple valid/ready command stream into single or auto-incrementing Wishbone cycles, and returns one response per beat.
- Drives the SoC Wishbone slave ports (syscon, GPIO, PTC) from a debug/bring-up source, such as a UART command decoder or a test sequencer.
- Has an ack timeout, so a dead or unmapped slave cannot hang the bus.

Parameters:
- AW, 32, Wishbone address width in bits.
- TIMEOUT, 255, maximum cycles stb may stay asserted without ack before the beat is aborted; must be ≥ 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready; equals (state==IDLE)
- i_cmd_adr  in  AW  start byte address; bits [1:0] are ignored and forced to 0 on the bus
- i_cmd_dat  in  32  write data, used for every beat
- i_cmd_sel  in  4  byte selects
- i_cmd_we  in  1  1 = write, 0 = read
- i_cmd_len  in  8  beat count minus 1 (0 → 1 beat, 255 → 256 beats)
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response accepted
- o_rsp_dat  out  32  read data; 0 for writes and errors
- o_rsp_err  out  1  beat timed out
- o_rsp_last  out  1  final response of the command
- o_wb_adr  out  AW  Wishbone address
- o_wb_dat  out  32  Wishbone write data
- o_wb_sel  out  4  Wishbone byte selects
- o_wb_we  out  1  Wishbone write enable
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- i_wb_rdt  in  32  Wishbone read data
- i_wb_ack  in  1  Wishbone acknowledge

Behaviour:
- Reset (async assert, released synchronously by design):
  - State = IDLE.
  - o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_err, o_rsp_last = 0.
  - o_wb_adr, o_wb_dat, o_wb_sel, o_rsp_dat, beat counter, timeout counter = 0.
  - o_cmd_ready = 1 during reset.
- States: IDLE, BUS, RSP. All outputs except o_cmd_ready are registered.
- IDLE:
  - On i_cmd_valid & o_cmd_ready: latch adr (with [1:0]=0), dat, sel, we, len.
  - Next cycle: state = BUS, o_wb_cyc = o_wb_stb = 1; first stb appears 1 cycle after acceptance.
- BUS:
  - cyc and stb stay high together. adr, dat, sel and we are stable for the whole beat.
  - Timeout counter is cleared on BUS entry and increments each cycle without ack.
  - i_wb_ack sampled high at a posedge:
    - Drop cyc/stb on that same edge.
    - o_rsp_dat = we ? 0 : i_wb_rdt.
    - o_rsp_err = 0.
    - o_rsp_last = (beats remaining == 0).
    - o_rsp_valid = 1; state = RSP.
  - Timeout counter reaches TIMEOUT−1 with no ack:
    - Drop cyc/stb.
    - o_rsp_dat = 0, o_rsp_err = 1, o_rsp_last = 1.
    - Remaining beats are discarded; state = RSP.
  - Ack on the same cycle as timeout expiry: ack wins and the beat completes normally.
  - An ack arriving while cyc = 0 is ignored in every state.
- RSP:
  - o_rsp_valid holds, with data/err/last stable, until i_rsp_ready.
  - On acceptance, clear o_rsp_valid.
  - If last: go to IDLE.
  - Otherwise: o_wb_adr += 4 (mod 2^AW; wrap-around allowed), decrement beat counter, go to BUS, and reassert cyc/stb the next cycle.
  - There is no cycle where rsp_valid and stb are both high.
- Beat latency: fastest command-to-response for a 0-wait slave (ack 1 cycle after stb) is 3 cycles from acceptance edge to o_rsp_valid.
- A new command is accepted only in IDLE. i_cmd_* is ignored in BUS and RSP.
- Reset mid-beat: cyc/stb drop immediately (asynchronously), with no response; the slave sees the cycle abort.

Test Plan:
- Single read: len=0, adr=0x00; slave returns 0xDEAD_0001 with ack 1 cycle after stb → one response: dat=0xDEAD_0001, err=0, last=1; acceptance→rsp_valid is 3 cycles; stb high for exactly 2 cycles.
- Write burst: len=2, adr=0x38, dat=0x0000_3F06, sel=0xF, we=1 → three Wishbone writes to 0x38, 0x3C, 0x40, all with dat=0x3F06; three responses with dat=0, the last having last=1.
- Response backpressure: read burst len=1 with i_rsp_ready held low 10 cycles → rsp_valid and data stable for 10 cycles; no second stb until acceptance.
- Timeout: TIMEOUT=8, slave never acks, len=3 → cyc/stb high exactly 8 cycles; a single response with err=1, last=1, dat=0; then IDLE, with cmd_ready=1.
- Ack on expiry cycle: TIMEOUT=8, ack on the 8th stb cycle → normal response with err=0 and data captured.
- Wrap + reset: AW=8, adr=0xFC, len=1 → second beat goes to 0x00; assert i_rst during the second beat → cyc/stb=0 and rsp_valid=0 immediately; after release, cmd_ready=1 and a new command is accepted.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone classic bus bundle for wb_cmd_master.
// The master modport is the initiator's view; the slave modport is the mirror seen by the environment.
interface wb_cmd_master_if #(
    parameter int unsigned AW = 32
);
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned LW = 8;

    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [AW-1:0] i_cmd_adr;
    logic [DW-1:0] i_cmd_dat;
    logic [SW-1:0] i_cmd_sel;
    logic          i_cmd_we;
    logic [LW-1:0] i_cmd_len;

    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_dat;
    logic          o_rsp_err;
    logic          o_rsp_last;

    logic [AW-1:0] o_wb_adr;
    logic [DW-1:0] o_wb_dat;
    logic [SW-1:0] o_wb_sel;
    logic          o_wb_we;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic [DW-1:0] i_wb_rdt;
    logic          i_wb_ack;

    modport master (
        input  i_cmd_valid, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_cmd_we, i_cmd_len,
        input  i_rsp_ready, i_wb_rdt, i_wb_ack,
        output o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_err, o_rsp_last,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );

    modport slave (
        output i_cmd_valid, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_cmd_we, i_cmd_len,
        output i_rsp_ready, i_wb_rdt, i_wb_ack,
        input  o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_err, o_rsp_last,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: turns valid/ready commands into single or incrementing
// bus beats, one response per beat, with a per-beat ack timeout.
module wb_cmd_master #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic            i_clk,
    input logic            i_rst,
    wb_cmd_master_if.master bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned LW = 8;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] ADR_MASK = ~AW'(3);

    logic [1:0]    state_q,     state_d;
    logic [AW-1:0] adr_q,       adr_d;
    logic [DW-1:0] dat_q,       dat_d;
    logic [SW-1:0] sel_q,       sel_d;
    logic          we_q,        we_d;
    logic          cyc_q,       cyc_d;
    logic          stb_q,       stb_d;
    logic [LW-1:0] beat_q,      beat_d;
    logic [TW-1:0] tmo_q,       tmo_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_dat_q,   rsp_dat_d;
    logic          rsp_err_q,   rsp_err_d;
    logic          rsp_last_q,  rsp_last_d;

    // Next-state and datapath; cyc/stb rise one cycle after BUS entry so every beat starts the same way.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;

        case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    state_d = BUS;
                    adr_d   = bus.i_cmd_adr & ADR_MASK;
                    dat_d   = bus.i_cmd_dat;
                    sel_d   = bus.i_cmd_sel;
                    we_d    = bus.i_cmd_we;
                    beat_d  = bus.i_cmd_len;
                end
            end
            BUS: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    tmo_d = '0;
                end else if (bus.i_wb_ack) begin
                    // Ack has priority over a timeout expiring on the same edge.
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : bus.i_wb_rdt;
                    rsp_err_d   = 1'b0;
                    rsp_last_d  = (beat_q == '0);
                    state_d     = RSP;
                end else if (tmo_q == TMO_LAST) begin
                    // Abort the beat and discard whatever beats remain.
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = RSP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RSP: begin
                if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        adr_d   = adr_q + AW'(4);
                        beat_d  = beat_q - LW'(1);
                        state_d = BUS;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops cyc/stb immediately, aborting any beat in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            beat_q      <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign bus.o_cmd_ready = (state_q == IDLE);
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_dat   = rsp_dat_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_rsp_last  = rsp_last_q;
    assign bus.o_wb_adr    = adr_q;
    assign bus.o_wb_dat    = dat_q;
    assign bus.o_wb_sel    = sel_q;
    assign bus.o_wb_we     = we_q;
    assign bus.o_wb_cyc    = cyc_q;
    assign bus.o_wb_stb    = stb_q;
endmodule
